// File: rtl/smart_car_pkg.sv
// Shared definitions for the smart-car mode scheduler.
// Contents:
//   CNT_W                  width of the dead/hold timers
//   DEAD_CYCLES_DEF        default motor-off dead time before a new mode (0.5 s at 50 MHz)
//   HOLD_CYCLES_DEF        default motor-off hold time after an obstacle clears
//   mode_t / MODE_*        applied-mode encodings
//   state_e                scheduler FSM state encoding
//   arb_mode()             request arbitration (remote wins over keys)
package smart_car_pkg;

    localparam int unsigned CNT_W           = 25;
    localparam int unsigned DEAD_CYCLES_DEF = 25000000;
    localparam int unsigned HOLD_CYCLES_DEF = 5000000;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_IDLE   = 2'b00;
    localparam mode_t MODE_TRACK  = 2'b01;
    localparam mode_t MODE_AVOID  = 2'b10;
    localparam mode_t MODE_REMOTE = 2'b11;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StBrake  = 2'd1,
        StCommit = 2'd2,
        StHalt   = 2'd3
    } state_e;

    // Remote request takes priority; the key request is dropped when both arrive together.
    function automatic mode_t arb_mode(input logic bt_req, input mode_t bt_mode,
                                       input mode_t key_mode);
        return bt_req ? bt_mode : key_mode;
    endfunction

endpackage

// File: rtl/tick_cnt.sv
// Shared 25-bit up-counter used for both the dead time and the hold time.
// A load clears the count and latches a new terminal value; clear only zeroes the count.
// Ports:
//   clk       system clock (rising edge)
//   rst       synchronous active-high reset
//   i_load    clear count and latch i_target as the terminal value
//   i_target  terminal value, loaded by i_load
//   i_clr     clear count, keep terminal value
//   i_en      count up by one
//   o_done    count equals the terminal value
module tick_cnt
    import smart_car_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_clr,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_target <= '0;
        end else if (i_load) begin
            r_count  <= '0;
            r_target <= i_target;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == r_target);

endmodule

// File: rtl/mode_sched.sv
// Drive-mode scheduler: applies key/remote mode requests with a motor-off dead time,
// and forces the motors off while an obstacle is present plus a hold time afterwards.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   key_req, key_mode   one-cycle key request and its mode
//   bt_req, bt_mode     one-cycle remote request and its mode (wins over keys)
//   obstacle            level, high while an obstacle is in range
//   mode_out            applied mode (00 idle, 01 track, 10 avoid, 11 remote)
//   motor_en            motor driver enable
//   mode_chg            one-cycle pulse when mode_out takes a new value
//   key_ack, bt_ack     one-cycle pulse when that request was accepted
//   busy                high whenever the scheduler is not in RUN
// All outputs are registered.
module mode_sched
    import smart_car_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_req,
    input  logic [1:0] key_mode,
    input  logic       bt_req,
    input  logic [1:0] bt_mode,
    input  logic       obstacle,
    output logic [1:0] mode_out,
    output logic       motor_en,
    output logic       mode_chg,
    output logic       key_ack,
    output logic       bt_ack,
    output logic       busy
);

    // BRAKE counts 0..DEAD_CYCLES-1 so it lasts exactly DEAD_CYCLES cycles.
    // HALT counts 0..HOLD_CYCLES: the first quiet cycle releases the obstacle hold,
    // then HOLD_CYCLES further quiet cycles are required before leaving.
    localparam logic [CNT_W-1:0] DEAD_TGT = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TGT = CNT_W'(HOLD_CYCLES);

    state_e           r_state;
    state_e           w_state_nxt;
    mode_t            r_mode_out;
    mode_t            r_pend;
    mode_t            w_req_mode;
    mode_t            w_pend_nxt;
    logic             w_req;
    logic             w_accept;
    logic             w_cnt_done;
    logic             w_cnt_load;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cnt_tgt;
    logic             r_motor_en;
    logic             r_mode_chg;
    logic             r_key_ack;
    logic             r_bt_ack;
    logic             r_busy;

    assign w_req      = key_req | bt_req;
    assign w_req_mode = arb_mode(bt_req, bt_mode, key_mode);
    // COMMIT is a single cycle that only applies pend_mode; requests there are dropped.
    assign w_accept   = w_req && (r_state != StCommit);
    assign w_pend_nxt = w_accept ? w_req_mode : r_pend;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun: begin
                if (obstacle) begin
                    w_state_nxt = StHalt;
                end else if (w_accept && (w_req_mode != r_mode_out)) begin
                    w_state_nxt = StBrake;
                end
            end
            StBrake: begin
                if (obstacle) begin
                    w_state_nxt = StHalt;
                end else if (w_cnt_done) begin
                    w_state_nxt = StCommit;
                end
            end
            StCommit: begin
                w_state_nxt = obstacle ? StHalt : StRun;
            end
            StHalt: begin
                if (!obstacle && w_cnt_done) begin
                    w_state_nxt = (w_pend_nxt != r_mode_out) ? StCommit : StRun;
                end
            end
        endcase
    end

    // Counter restarts on every state entry; in HALT an obstacle holds it at zero.
    always_comb begin
        w_cnt_load = (w_state_nxt != r_state);
        w_cnt_tgt  = (w_state_nxt == StHalt) ? HOLD_TGT : DEAD_TGT;
        w_cnt_clr  = (r_state == StHalt) && obstacle;
        w_cnt_en   = (r_state == StBrake) || ((r_state == StHalt) && !obstacle);
    end

    tick_cnt u_tick_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_cnt_load),
        .i_target (w_cnt_tgt),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .o_done   (w_cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_mode_out <= MODE_IDLE;
            r_pend     <= MODE_IDLE;
            r_motor_en <= 1'b1;
            r_mode_chg <= 1'b0;
            r_key_ack  <= 1'b0;
            r_bt_ack   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_key_ack  <= w_accept & ~bt_req;
            r_bt_ack   <= w_accept & bt_req;
            r_motor_en <= (w_state_nxt == StRun);
            r_busy     <= (w_state_nxt != StRun);
            r_mode_chg <= 1'b0;
            // mode_out is updated on entry so the new value is visible during COMMIT.
            // A pending mode that was overwritten back to the current one changes nothing,
            // so no mode_chg pulse is raised for it.
            if (w_state_nxt == StCommit) begin
                r_mode_out <= w_pend_nxt;
                r_mode_chg <= (w_pend_nxt != r_mode_out);
            end
        end
    end

    assign mode_out = r_mode_out;
    assign motor_en = r_motor_en;
    assign mode_chg = r_mode_chg;
    assign key_ack  = r_key_ack;
    assign bt_ack   = r_bt_ack;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mode_sched.sv
module tb_mode_sched;

    localparam int unsigned DEAD = 4;
    localparam int unsigned HOLD = 3;

    localparam int PH_RUN    = 0;
    localparam int PH_BRAKE  = 1;
    localparam int PH_COMMIT = 2;
    localparam int PH_HALT   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_req = 1'b0;
    logic [1:0] key_mode = 2'b00;
    logic       bt_req = 1'b0;
    logic [1:0] bt_mode = 2'b00;
    logic       obstacle = 1'b0;
    logic [1:0] mode_out;
    logic       motor_en;
    logic       mode_chg;
    logic       key_ack;
    logic       bt_ack;
    logic       busy;

    mode_sched #(
        .DEAD_CYCLES (DEAD),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_req  (key_req),
        .key_mode (key_mode),
        .bt_req   (bt_req),
        .bt_mode  (bt_mode),
        .obstacle (obstacle),
        .mode_out (mode_out),
        .motor_en (motor_en),
        .mode_chg (mode_chg),
        .key_ack  (key_ack),
        .bt_ack   (bt_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic       men;
        logic       chg;
        logic       ka;
        logic       ba;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    // Reference model, in terms of absolute cycle deadlines.
    int         m_phase     = PH_RUN;
    logic [1:0] m_mode      = 2'b00;
    logic [1:0] m_pend      = 2'b00;
    int         m_commit_at = 0;
    int         m_quiet     = 0;

    // Predict outputs visible after the coming clock edge from the inputs now driven.
    task automatic model_and_push();
        exp_t       e;
        logic       acc;
        logic [1:0] rm;
        logic [1:0] np;
        int         nxt;
        int         t1;
        t1    = cyc + 1;
        e.ka  = 1'b0;
        e.ba  = 1'b0;
        e.chg = 1'b0;
        if (rst) begin
            m_phase = PH_RUN;
            m_mode  = 2'b00;
            m_pend  = 2'b00;
        end else begin
            rm   = bt_req ? bt_mode : key_mode;
            acc  = (key_req || bt_req) && (m_phase != PH_COMMIT);
            e.ka = acc && !bt_req;
            e.ba = acc && bt_req;
            np   = acc ? rm : m_pend;
            nxt  = m_phase;
            case (m_phase)
                PH_RUN: begin
                    if (obstacle) nxt = PH_HALT;
                    else if (acc && rm != m_mode) begin
                        nxt = PH_BRAKE;
                        m_commit_at = t1 + int'(DEAD);
                    end
                end
                PH_BRAKE: begin
                    if (obstacle) nxt = PH_HALT;
                    else if (t1 == m_commit_at) nxt = PH_COMMIT;
                end
                PH_COMMIT: nxt = obstacle ? PH_HALT : PH_RUN;
                default: begin
                    // Leave after HOLD+1 consecutive obstacle-free HALT cycles.
                    m_quiet = obstacle ? 0 : m_quiet + 1;
                    if (m_quiet == int'(HOLD) + 1) nxt = (np != m_mode) ? PH_COMMIT : PH_RUN;
                end
            endcase
            if (nxt == PH_HALT && m_phase != PH_HALT) m_quiet = 0;
            m_pend = np;
            if (nxt == PH_COMMIT) begin
                e.chg  = (np != m_mode);
                m_mode = np;
            end
            m_phase = nxt;
        end
        e.cyc  = t1;
        e.mode = m_mode;
        e.men  = (m_phase == PH_RUN);
        e.busy = (m_phase != PH_RUN);
        q.push_back(e);
    endtask

    task automatic step(input logic r, input logic kr, input logic [1:0] km,
                        input logic br, input logic [1:0] bm, input logic ob);
        rst      = r;
        key_req  = kr;
        key_mode = km;
        bt_req   = br;
        bt_mode  = bm;
        obstacle = ob;
        model_and_push();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    endtask

    // Monitor: compare the DUT outputs each cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_checks++;
                n_errs++;
                $display("FAIL stale_expect cyc=%0d got none required cyc=%0d", cyc, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_checks++;
                if ({mode_out, motor_en, mode_chg, key_ack, bt_ack, busy} !==
                    {e.mode, e.men, e.chg, e.ka, e.ba, e.busy}) begin
                    n_errs++;
                    $display({"FAIL outputs cyc=%0d got mode=%b men=%b chg=%b kack=%b back=%b ",
                              "busy=%b required mode=%b men=%b chg=%b kack=%b back=%b busy=%b"},
                             cyc, mode_out, motor_en, mode_chg, key_ack, bt_ack, busy,
                             e.mode, e.men, e.chg, e.ka, e.ba, e.busy);
                end
            end
        end
    end

    initial begin
        logic       obs_l;
        logic       r;
        logic       kr;
        logic       br;
        logic [1:0] km;
        logic [1:0] bm;

        // Reset and settle.
        step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        idle(2);

        // Key request to track mode.
        step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        idle(8);
        // Same mode again: ack only.
        step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        idle(3);
        // Request 10, then 11 at BRAKE cycle 2.
        step(1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
        idle(8);
        // Back to idle, then simultaneous key 10 / remote 11.
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        idle(8);
        step(1'b0, 1'b1, 2'b10, 1'b1, 2'b11, 1'b0);
        idle(8);
        // Obstacle for 6 cycles with a remote request for 10 during HALT.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'b00, (i == 3), 2'b10, 1'b1);
        idle(12);
        // Reset at BRAKE cycle 2.
        step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        idle(8);
        // Requests coincident with reset are ignored.
        step(1'b1, 1'b1, 2'b10, 1'b1, 2'b11, 1'b0);
        idle(4);

        // Randomized traffic.
        obs_l = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) obs_l = ~obs_l;
            r  = ($urandom_range(0, 299) == 0);
            kr = ($urandom_range(0, 5) == 0);
            br = ($urandom_range(0, 7) == 0);
            km = 2'($urandom_range(0, 3));
            bm = 2'($urandom_range(0, 3));
            step(r, kr, km, br, bm, obs_l);
        end
        idle(20);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errs++;
            $display("FAIL queue_drain got %0d pending required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
